// File: rtl/pip_pkg.sv
// Shared definitions for the EX/MEM elastic pipeline register.
// Control bundle layout and occupancy encoding live here so entry and top agree.
package pip_pkg;

  localparam int DSIZE  = 16;
  localparam int ADDR_W = 4;

  localparam int CTRL_W        = 4;
  localparam int CTRL_MEMWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_WEN      = 3;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic ctrl_t pack_ctrl(input logic mem_write, input logic mem_read,
                                      input logic mem_to_reg, input logic wen);
    ctrl_t c;
    c                = '0;
    c[CTRL_MEMWRITE] = mem_write;
    c[CTRL_MEMREAD]  = mem_read;
    c[CTRL_MEMTOREG] = mem_to_reg;
    c[CTRL_WEN]      = wen;
    return c;
  endfunction

endpackage

// File: rtl/pip_stage_skid_if.sv
// One valid/ready channel carrying an EX/MEM entry (address, data, store data, control).
// master drives valid + payload, slave drives ready.
interface pip_stage_skid_if import pip_pkg::*; #(
  parameter int AW = ADDR_W,
  parameter int DW = DSIZE
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] rdata2;
  logic          memWrite;
  logic          memRead;
  logic          memToReg;
  logic          wen;

  modport master (output valid, w_addr, w_data, rdata2, memWrite, memRead, memToReg, wen,
                  input  ready);
  modport slave  (input  valid, w_addr, w_data, rdata2, memWrite, memRead, memToReg, wen,
                  output ready);
endinterface

// File: rtl/pip_stage_entry.sv
// Single payload + control holding register with load enable.
// Synchronous active-low reset clears everything to zero.
module pip_stage_entry import pip_pkg::*; #(
  parameter int AW = ADDR_W,
  parameter int DW = DSIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ld,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] i_rdata2,
  input  ctrl_t         i_ctrl,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic [DW-1:0] o_rdata2,
  output ctrl_t         o_ctrl
);
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_rdata2;
  ctrl_t         r_ctrl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_rdata2 <= '0;
      r_ctrl   <= '0;
    end else if (i_ld) begin
      r_addr   <= i_addr;
      r_data   <= i_data;
      r_rdata2 <= i_rdata2;
      r_ctrl   <= i_ctrl;
    end
  end

  assign o_addr   = r_addr;
  assign o_data   = r_data;
  assign o_rdata2 = r_rdata2;
  assign o_ctrl   = r_ctrl;
endmodule

// File: rtl/pip_stage_skid.sv
// Elastic EX/MEM register: main + skid entry, flush to bubbles, saturating stall counter.
// in_ready is !skid_valid (registered); control outputs are gated by out_valid.
module pip_stage_skid import pip_pkg::*; #(
  parameter int AW          = ADDR_W,
  parameter int DW          = DSIZE,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pip_stage_skid_if.slave        in_if,
  pip_stage_skid_if.master       out_if,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic          w_main_vld, w_skid_vld, w_accept, w_drain;
  logic          w_main_ld, w_main_from_skid, w_skid_ld;
  ctrl_t         w_in_ctrl, w_main_ctrl, w_skid_ctrl, w_main_ctrl_in;
  logic [AW-1:0] w_main_addr, w_skid_addr, w_main_addr_in;
  logic [DW-1:0] w_main_data, w_skid_data, w_main_data_in;
  logic [DW-1:0] w_main_rd2, w_skid_rd2, w_main_rd2_in;

  assign w_main_vld   = (r_state != OCC_EMPTY);
  assign w_skid_vld   = (r_state == OCC_FULL);
  assign in_if.ready  = !w_skid_vld;
  assign w_accept     = in_if.valid && in_if.ready;
  assign w_drain      = w_main_vld && out_if.ready;
  assign w_in_ctrl    = pack_ctrl(in_if.memWrite, in_if.memRead, in_if.memToReg, in_if.wen);

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    case (r_state)
      OCC_EMPTY: if (w_accept) begin
        w_state_nxt = OCC_ONE;
        w_main_ld   = 1'b1;
      end
      OCC_ONE: begin
        if (w_accept && w_drain) begin
          w_main_ld = 1'b1;
        end else if (w_accept) begin
          w_skid_ld   = 1'b1;
          w_state_nxt = OCC_FULL;
        end else if (w_drain) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: if (w_drain) begin
        w_main_ld        = 1'b1;
        w_main_from_skid = 1'b1;
        w_state_nxt      = OCC_ONE;
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
    // Flush only clears valids; payload registers are left untouched.
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
      w_main_ld   = 1'b0;
      w_skid_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= OCC_EMPTY;
    else      r_state <= w_state_nxt;
  end

  assign w_main_addr_in = w_main_from_skid ? w_skid_addr : in_if.w_addr;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_if.w_data;
  assign w_main_rd2_in  = w_main_from_skid ? w_skid_rd2  : in_if.rdata2;
  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : w_in_ctrl;

  pip_stage_entry #(.AW(AW), .DW(DW)) u_main (
    .clk(clk), .rst(rst), .i_ld(w_main_ld),
    .i_addr(w_main_addr_in), .i_data(w_main_data_in), .i_rdata2(w_main_rd2_in),
    .i_ctrl(w_main_ctrl_in),
    .o_addr(w_main_addr), .o_data(w_main_data), .o_rdata2(w_main_rd2), .o_ctrl(w_main_ctrl)
  );

  pip_stage_entry #(.AW(AW), .DW(DW)) u_skid (
    .clk(clk), .rst(rst), .i_ld(w_skid_ld),
    .i_addr(in_if.w_addr), .i_data(in_if.w_data), .i_rdata2(in_if.rdata2),
    .i_ctrl(w_in_ctrl),
    .o_addr(w_skid_addr), .o_data(w_skid_data), .o_rdata2(w_skid_rd2), .o_ctrl(w_skid_ctrl)
  );

  assign out_if.valid    = w_main_vld;
  assign out_if.w_addr   = w_main_addr;
  assign out_if.w_data   = w_main_data;
  assign out_if.rdata2   = w_main_rd2;
  assign out_if.memWrite = w_main_ctrl[CTRL_MEMWRITE] & w_main_vld;
  assign out_if.memRead  = w_main_ctrl[CTRL_MEMREAD]  & w_main_vld;
  assign out_if.memToReg = w_main_ctrl[CTRL_MEMTOREG] & w_main_vld;
  assign out_if.wen      = w_main_ctrl[CTRL_WEN]      & w_main_vld;

  // Counts MEM-side stall cycles; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (w_main_vld && !out_if.ready && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;
endmodule

// File: doc/pip_stage_skid.md
# pip_stage_skid

Parametrised, elastic EX/MEM pipeline register for the 5-stage datapath. It carries write address, ALU result, store data and memory/write-back control from EX to MEM. It replaces the fixed always-load register with a valid/ready handshake, a one-entry skid buffer, a flush that turns in-flight entries into bubbles, and a saturating stall counter. It sits between the EX stage and the data-memory/MEM stage.

## Interface
- AW, 4: register write-address width
- DW, 16: ALU result / store data width (`DSIZE`)
- STALL_CNT_W, 16: stall counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  squash all held entries (branch/exception)
- in_valid  in  1  EX presents an entry
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- w_addr_in  in  AW  destination register
- w_data_in  in  DW  ALU result / memory address
- rdata2_in  in  DW  store data
- memWrite_in, memRead_in, memToReg_in, wen_in  in  1 each  control
- out_valid  out  1  MEM entry valid
- out_ready  in  1  MEM consumes entry this cycle
- w_addr_out  out  AW; w_data_out, rdata2_out  out  DW  payload of head entry
- memWrite_out, memRead_out, memToReg_out, wen_out  out  1 each  head control, forced 0 when !out_valid
- stall_cnt  out  STALL_CNT_W  cycles with out_valid && !out_ready

## Operation
- Two entries: main (drives outputs) and skid. Occupancy states: EMPTY, ONE (main valid), FULL (main + skid valid).
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- EMPTY: accept → main ← in, go to ONE.
- ONE: accept && drain → main ← in, stay ONE. Accept && !drain → skid ← in, go to FULL. Drain && !accept → EMPTY. Otherwise hold.
- FULL: in_ready = 0, so no accept. Drain → main ← skid, go to ONE. Otherwise hold.
- Order is strictly FIFO. No entry is lost or duplicated.
- flush has priority over all transitions. The next state is EMPTY, and an input presented in the flush cycle is dropped. Payload registers keep stale data; only the valids clear.
- Control outputs are ANDed with main_valid, so a bubble never writes memory or the register file.
- stall_cnt increments when out_valid && !out_ready and saturates at all-ones. Only rst clears it; flush does not.

## Timing
- Reset (rst = 0 at an edge): both valids 0, all payload and control outputs 0, stall_cnt 0, in_ready 1.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 entry/cycle while out_ready = 1.
- in_ready falls the cycle after the stage enters FULL. It rises the cycle after the drain from FULL.
- Accept and drain in the same cycle in FULL cannot occur, because in_ready = 0.
- Flush together with drain: the drained entry counts as consumed by MEM, and the stage is EMPTY next cycle.
- Reset mid-operation behaves exactly like reset from idle.

## Structure
- Shared package `pip_pkg`:
  - `DSIZE`, `AW` defaults.
  - Control-bundle width (4) and bit positions: memWrite = 0, memRead = 1, memToReg = 2, wen = 3.
  - Occupancy state encoding.
- Sub-module `pip_stage_entry`: one payload + control register with load enable. Instantiate twice (main, skid).
- Top level holds the occupancy FSM, the output gating and the stall counter.

## Test plan
- Reset: rst = 0 for 2 cycles with in_valid = 1 → all outputs 0, stall_cnt = 0, in_ready = 1; nothing accepted.
- Stream: out_ready = 1, send addr 1..4 with data 0x1111..0x4444 back to back → each appears 1 cycle later, in order, with out_valid high 4 consecutive cycles.
- Backpressure: out_ready = 0, send A (addr 5), then B (addr 6) → A on outputs, in_ready = 0 the next cycle, C (addr 7) held upstream. Then out_ready = 1 → A, B, C exit in order, and stall_cnt equals the stalled-cycle count.
- Flush in FULL with in_valid = 1 and memWrite/wen set → next cycle out_valid = 0, memWrite_out = 0, wen_out = 0, in_ready = 1, and the input is never output.
- Saturation: STALL_CNT_W = 3, hold out_valid = 1 with out_ready = 0 for 10 cycles → stall_cnt = 7 and stays 7.
- Reset mid-FULL → next cycle EMPTY, all outputs 0, and subsequent streaming works as in the Stream test.
